// File: rtl/seg7_bin_display.sv
// Binary-to-decimal 7-segment driver. Sequential double-dabble, registered
// outputs, leading-zero blanking, overflow dashes. Optional blink: SEG7_BLINK_EN.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   load         start conversion (ignored while busy)
//   value        unsigned binary input, WIDTH bits
//   blank_lz     leading-zero blanking, sampled with load
//   blink        (SEG7_BLINK_EN only) blank all digits on phase=1
//   busy, done   conversion in progress / one-cycle result pulse
//   overflow     last value exceeded 10^DIGITS-1
//   hex          DIGITS x 7 active-low segments, digit 0 in hex[6:0]
module seg7_bin_display #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [WIDTH-1:0]    value,
  input  logic                blank_lz,
`ifdef SEG7_BLINK_EN
  input  logic                blink,
`endif
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [7*DIGITS-1:0] hex
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int HW = 7 * DIGITS;
  localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              blank_q, blank_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [HW-1:0]     hex_q, hex_d;

  logic [BW-1:0]     bcd_adj;
  logic [HW-1:0]     commit_hex;
  logic              in_ovf;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = SEG_OFF;
    endcase
  endfunction

  assign in_ovf = {{(32-WIDTH){1'b0}}, value} > MAXV;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; a digit blanks while everything
  // above it (and itself) is still zero.
  always_comb begin
    logic       hz;
    logic [6:0] s;
    hz = 1'b1;
    commit_hex = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hz = hz && (bcd_q[4*i +: 4] == 4'd0);
      s  = dec7(bcd_q[4*i +: 4]);
      if (blank_q && (i != 0) && hz)
        s = SEG_OFF;
      if (ovf_pend_q)
        s = SEG_DASH;
      commit_hex[7*i +: 7] = s;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    hex_d      = hex_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d      = value;
          blank_d    = blank_lz;
          ovf_pend_d = in_ovf;
          bcd_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = COMMIT;
      end
      COMMIT: begin
        hex_d   = commit_hex;
        ovf_d   = ovf_pend_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      blank_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= {DIGITS{SEG_0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      hex_q      <= hex_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

`ifdef SEG7_BLINK_EN
  logic [31:0] bcnt_q, bcnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q + 32'd1;
    phase_d = phase_q;
    if (bcnt_q >= 32'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign hex = (blink && phase_q) ? {HW{1'b1}} : hex_q;
`else
  assign hex = hex_q;
`endif

endmodule

// File: tb/tb_seg7_bin_display.sv
// Scoreboard bench for seg7_bin_display (WIDTH=14, DIGITS=4).
// Random and directed loads checked against a decimal reference model.
module tb_seg7_bin_display;

  localparam int W = 14;
  localparam int D = 4;
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [7*D-1:0] hex;
    logic           ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load = 1'b0;
  logic [W-1:0]   value = '0;
  logic           blank_lz = 1'b0;
  logic           busy, done, overflow;
  logic [7*D-1:0] hex;
`ifdef SEG7_BLINK_EN
  logic           blink = 1'b0;
`endif

  seg7_bin_display #(.WIDTH(W), .DIGITS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
`ifdef SEG7_BLINK_EN
    .blink    (blink),
`endif
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex      (hex)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   cnt = 0;
  logic exp_done = 1'b0;
  logic rst_seen = 1'b0;

  function automatic exp_t ref_model(int v, bit b);
    exp_t e;
    int   p;
    p = 1;
    e.ovf = (v > 10 ** D - 1);
    for (int i = 0; i < D; i++) begin
      if (e.ovf)
        e.hex[7*i +: 7] = 7'b0111111;
      else if (b && i > 0 && v < p)
        e.hex[7*i +: 7] = 7'b1111111;
      else
        e.hex[7*i +: 7] = SEG[(v / p) % 10];
      p = p * 10;
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference timing: an accepted load keeps the block busy W+1 cycles.
  always @(posedge clk) begin
    rst_seen <= reset;
    if (reset) begin
      cnt      <= 0;
      exp_done <= 1'b0;
      q.delete();
    end else begin
      exp_done <= (cnt == 1);
      if (load && cnt == 0) begin
        cnt <= W + 1;
        q.push_back(ref_model(int'(value), blank_lz));
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  initial begin : monitor
    exp_t hold;
    exp_t e;
    hold.hex = {D{7'b1000000}};
    hold.ovf = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        hold.hex = {D{7'b1000000}};
        hold.ovf = 1'b0;
      end
      check("busy", 32'(busy), 32'(cnt != 0));
      check("done", 32'(done), 32'(exp_done));
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          hold = e;
        end
      end
      check("hex", 32'(hex), 32'(hold.hex));
      check("overflow", 32'(overflow), 32'(hold.ovf));
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(int v, bit b);
    load     = 1'b1;
    value    = W'(v);
    blank_lz = b;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    do_load(1234, 0);  cyc(20);
    do_load(7, 1);     cyc(20);
    do_load(0, 1);     cyc(20);
    do_load(0, 0);     cyc(20);
    do_load(10000, 1); cyc(20);
    do_load(9999, 0);  cyc(20);
    do_load(16383, 0); cyc(20);
    do_load(1000, 1);  cyc(20);
    do_load(42, 0);    cyc(2);
    do_load(5555, 0);  cyc(20);
    do_load(1234, 0);  cyc(3);
    reset = 1'b1;      cyc(1);
    reset = 1'b0;      cyc(20);
    do_load(321, 0);   cyc(14);
    do_load(8, 1);     cyc(20);
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        value = W'($urandom_range(9990, 10010));
      else if ($urandom_range(0, 1) == 0)
        value = W'($urandom_range(0, 120));
      else
        value = W'($urandom_range(0, 16383));
      blank_lz = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    load  = 1'b0;
    reset = 1'b0;
    cyc(25);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
